dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and sequencer in front of the single-ported `data_memory`. It shares the memory between port 0 (CPU load/store unit) and port 1 (program loader / debug). The memory has a one-cycle registered read and a 4 KiB window. The block latches one request at a time, checks alignment and range, drives exactly one memory enable pulse, and returns a one-cycle response on the winning port with correctly extended load data.

## Interface
Parameters:
- `ADDR_LIMIT_BITS`, default 12: byte-address width backed by RAM. Any set bit at or above this position is an error.

Ports:
- `clk`  in  1  clock; all logic on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `p0_req`, `p1_req`  in  1  request valid; held until the matching `gnt`
- `p0_we`, `p1_we`  in  1  1 = store, 0 = load
- `p0_type`, `p1_type`  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- `p0_addr`, `p1_addr`  in  32  byte address
- `p0_wdata`, `p1_wdata`  in  32  store data, right-aligned
- `p0_gnt`, `p1_gnt`  out  1  combinational; request accepted this cycle
- `p0_rvalid`, `p1_rvalid`  out  1  one-cycle completion pulse for loads and stores
- `rsp_data`  out  32  load result; 0 for stores and errors
- `rsp_err`  out  1  qualifies the active `pN_rvalid`; misaligned, illegal type, or out of range
- `mem_read_en`, `mem_write_en`  out  1  to memory
- `load_type`, `store_type`  out  3  to memory
- `ram_address_load`, `ram_address_store`  out  32  to memory; both driven with the latched address
- `data_in`  out  32  store data to memory
- `data_out`  in  32  memory read data, valid the cycle after `mem_read_en`

## Operation
- FSM states: IDLE, ISSUE, RESP.
- **IDLE**
  - If any `pN_req` is high, pick a winner and assert its `gnt` (combinational, IDLE only).
  - Latch we/type/addr/wdata and the port ID, then go to ISSUE. Otherwise stay in IDLE.
- **Arbitration:** round-robin on a 1-bit `last_grant` register.
  - With one requester, that requester wins.
  - With both, the port ≠ `last_grant` wins.
  - `last_grant` updates on every grant.
- **Error check** (done on latched fields when entering ISSUE; erroneous requests get no memory enable):
  - H/HU with `addr[0]`=1.
  - W with `addr[1:0]`≠0.
  - Load type 011, 110 or 111.
  - Store type other than 000/001/010.
  - Any of `addr[31:ADDR_LIMIT_BITS]` ≠ 0.
- **ISSUE** (one cycle)
  - No error: assert `mem_read_en` (load) or `mem_write_en` (store) with type, address and `data_in` from the latch.
  - Error: no enable.
  - Always go to RESP.
- **RESP** (one cycle)
  - Assert `pN_rvalid` for the latched port.
  - `rsp_err` = error flag.
  - `rsp_data` per load type, taken from `data_out`:
    - B/H/W: `data_out` unchanged.
    - BU: {24'b0, `data_out[7:0]`}.
    - HU: {16'b0, `data_out[15:0]`}.
  - `rsp_data` = 0 on store or error.
  - Go to IDLE. No grant is issued in RESP.
- `rsp_data` and `rsp_err` are registered outputs. They hold their value between responses and are meaningful only with `rvalid`.
- A port may re-request starting the cycle after its `rvalid`.

## Timing
- Reset values:
  - state = IDLE, `last_grant` = 1 (port 0 wins the first tie).
  - All `gnt`, `rvalid`, `mem_read_en`, `mem_write_en` = 0.
  - `rsp_data` = 0, `rsp_err` = 0.
  - `load_type`, `store_type`, addresses and `data_in` = 0.
- Latency: request in IDLE at cycle N → `gnt` at N, memory enable at N+1, `rvalid` at N+2, next grant possible at N+3. Peak throughput is one access per 3 cycles.
- Exactly one enable pulse per accepted non-error request. The enable is never high outside ISSUE.
- `rst` asserted in any state: the next edge forces reset values. An in-flight access produces no `rvalid`. A write already in ISSUE at that edge may still commit.
- A request that drops before its grant is simply not served. Requests arriving in ISSUE or RESP wait for IDLE.

## Test plan
- Reset, then p0 store W 0x00000010 data 0xDEADBEEF → `gnt` at cycle 0, `mem_write_en` at 1, `p0_rvalid` at 2 with `rsp_err`=0. Then p0 load W 0x10 → `rsp_data`=0xDEADBEEF.
- Store B 0x80 at 0x13; load BU 0x13 → 0x00000080; load B 0x13 → 0xFFFFFF80. Store H 0x8001 at 0x22; load HU → 0x00008001.
- p0 and p1 request together continuously → grants alternate p0, p1, p0, p1 exactly 3 cycles apart. Each `rvalid` arrives only on the granted port.
- Load W 0x02, load H 0x05, store W 0x1000, load type 011 → each gives `rvalid` with `rsp_err`=1 and `rsp_data`=0, and no memory enable asserts. A following valid load of 0x00 is unaffected.
- Assert `rst` during ISSUE of a load → no `rvalid`; all outputs at reset values next cycle. Then a simultaneous p0/p1 request grants p0 first.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-ported data memory.
// One request is accepted at a time (IDLE -> ISSUE -> RESP). It is checked
// for alignment, type and range, gets at most one memory enable pulse, and
// is answered with a one-cycle rvalid on the port that won the grant.
module dmem_arbiter #(
  parameter int ADDR_LIMIT_BITS = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p1_req,
  input  logic        p0_we,
  input  logic        p1_we,
  input  logic [2:0]  p0_type,
  input  logic [2:0]  p1_type,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p0_wdata,
  input  logic [31:0] p1_wdata,
  output logic        p0_gnt,
  output logic        p1_gnt,
  output logic        p0_rvalid,
  output logic        p1_rvalid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        mem_read_en,
  output logic        mem_write_en,
  output logic [2:0]  load_type,
  output logic [2:0]  store_type,
  output logic [31:0] ram_address_load,
  output logic [31:0] ram_address_store,
  output logic [31:0] data_in,
  input  logic [31:0] data_out
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

  state_t      r_state;
  logic        r_last_grant;   // port that received the most recent grant
  logic        r_port;         // port of the request in flight
  logic        r_we;
  logic [2:0]  r_type;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_err;
  logic        r_rd_en;
  logic        r_wr_en;
  logic        r_rvalid0;
  logic        r_rvalid1;
  logic        r_rsp_err;
  logic [31:0] r_rsp_data;

  logic        w_idle;
  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_sel;
  logic        w_we;
  logic [2:0]  w_type;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_err;
  logic [31:0] w_resp_data;

  // Round-robin grant: a lone requester wins, on a tie the port that did
  // not win last time goes first. Grants are only offered in IDLE.
  assign w_idle = (r_state == S_IDLE);
  assign w_gnt0 = w_idle & p0_req & (~p1_req | r_last_grant);
  assign w_gnt1 = w_idle & p1_req & (~p0_req | ~r_last_grant);
  assign w_sel  = w_gnt1;

  assign w_we    = w_sel ? p1_we    : p0_we;
  assign w_type  = w_sel ? p1_type  : p0_type;
  assign w_addr  = w_sel ? p1_addr  : p0_addr;
  assign w_wdata = w_sel ? p1_wdata : p0_wdata;

  // Error classification of the winning request, captured with the latch.
  always_comb begin
    w_err = 1'b0;
    if (w_type[1:0] == 2'b01 && w_addr[0])
      w_err = 1'b1;
    if (w_type[1:0] == 2'b10 && w_addr[1:0] != 2'b00)
      w_err = 1'b1;
    if (!w_we && (w_type == 3'b011 || w_type == 3'b110 || w_type == 3'b111))
      w_err = 1'b1;
    if (w_we && !(w_type == 3'b000 || w_type == 3'b001 || w_type == 3'b010))
      w_err = 1'b1;
    if (|w_addr[31:ADDR_LIMIT_BITS])
      w_err = 1'b1;
  end

  // Load result formatting: the memory already sign-extends B/H, so only
  // the unsigned variants need their upper bits cleared.
  always_comb begin
    w_resp_data = data_out;
    case (r_type)
      3'b100:  w_resp_data = {24'b0, data_out[7:0]};
      3'b101:  w_resp_data = {16'b0, data_out[15:0]};
      default: w_resp_data = data_out;
    endcase
    if (r_we || r_err)
      w_resp_data = '0;
  end

  // Sequencer: latch in IDLE, pulse the memory in ISSUE, answer in RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_port       <= 1'b0;
      r_we         <= 1'b0;
      r_type       <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_err        <= 1'b0;
      r_rd_en      <= 1'b0;
      r_wr_en      <= 1'b0;
      r_rvalid0    <= 1'b0;
      r_rvalid1    <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_rsp_data   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt0 || w_gnt1) begin
            r_last_grant <= w_sel;
            r_port       <= w_sel;
            r_we         <= w_we;
            r_type       <= w_type;
            r_addr       <= w_addr;
            r_wdata      <= w_wdata;
            r_err        <= w_err;
            r_rd_en      <= ~w_we & ~w_err;
            r_wr_en      <= w_we & ~w_err;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_rd_en   <= 1'b0;
          r_wr_en   <= 1'b0;
          r_rvalid0 <= ~r_port;
          r_rvalid1 <= r_port;
          r_rsp_err <= r_err;
          r_state   <= S_RESP;
        end
        S_RESP: begin
          r_rvalid0  <= 1'b0;
          r_rvalid1  <= 1'b0;
          r_rsp_data <= w_resp_data;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign p0_gnt            = w_gnt0;
  assign p1_gnt            = w_gnt1;
  assign p0_rvalid         = r_rvalid0;
  assign p1_rvalid         = r_rvalid1;
  assign rsp_err           = r_rsp_err;
  // Read data arrives from the memory register during RESP; outside RESP
  // the last response is held.
  assign rsp_data          = (r_state == S_RESP) ? w_resp_data : r_rsp_data;
  assign mem_read_en       = r_rd_en;
  assign mem_write_en      = r_wr_en;
  assign load_type         = r_type;
  assign store_type        = r_type;
  assign ram_address_load  = r_addr;
  assign ram_address_store = r_addr;
  assign data_in           = r_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural 4 KiB memory that
// sign-extends B/H reads itself (so BU/HU rely on the arbiter's zero-extend).
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p1_req, p0_we, p1_we;
  logic [2:0]  p0_type, p1_type;
  logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
  logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        mem_read_en, mem_write_en;
  logic [2:0]  load_type, store_type;
  logic [31:0] ram_address_load, ram_address_store, data_in;
  logic [31:0] data_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_LIMIT_BITS(12)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p1_req(p1_req), .p0_we(p0_we), .p1_we(p1_we),
    .p0_type(p0_type), .p1_type(p1_type), .p0_addr(p0_addr), .p1_addr(p1_addr),
    .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .load_type(load_type), .store_type(store_type),
    .ram_address_load(ram_address_load), .ram_address_store(ram_address_store),
    .data_in(data_in), .data_out(data_out)
  );

  // Behavioural memory: registered read, little-endian byte lanes.
  logic [31:0] mem [0:1023];

  function automatic logic [31:0] rd_fmt(input logic [31:0] w, input logic [2:0] t,
                                         input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = w[{off[1], 4'b0000} +: 16];
    case (t[1:0])
      2'b00:   return {{24{b[7]}}, b};
      2'b01:   return {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_write_en) begin
      case (store_type[1:0])
        2'b00: mem[ram_address_store[11:2]][{ram_address_store[1:0], 3'b000} +: 8] <= data_in[7:0];
        2'b01: mem[ram_address_store[11:2]][{ram_address_store[1], 4'b0000} +: 16] <= data_in[15:0];
        default: mem[ram_address_store[11:2]] <= data_in;
      endcase
    end
    if (mem_read_en)
      data_out <= rd_fmt(mem[ram_address_load[11:2]], load_type, ram_address_load[1:0]);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    p0_req = 0; p1_req = 0; p0_we = 0; p1_we = 0;
    p0_type = 0; p1_type = 0; p0_addr = 0; p1_addr = 0;
    p0_wdata = 0; p1_wdata = 0;
  endtask

  task automatic drive(input logic port, input logic req, input logic we,
                       input logic [2:0] typ, input logic [31:0] addr, input logic [31:0] wd);
    if (port) begin
      p1_req = req; p1_we = we; p1_type = typ; p1_addr = addr; p1_wdata = wd;
    end else begin
      p0_req = req; p0_we = we; p0_type = typ; p0_addr = addr; p0_wdata = wd;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_gnt"},    {30'b0, p1_gnt, p0_gnt}, 32'h0);
    chk({tag, "_rvalid"}, {30'b0, p1_rvalid, p0_rvalid}, 32'h0);
    chk({tag, "_en"},     {30'b0, mem_write_en, mem_read_en}, 32'h0);
    chk({tag, "_rdata"},  rsp_data, 32'h0);
    chk({tag, "_rerr"},   {31'b0, rsp_err}, 32'h0);
    chk({tag, "_types"},  {26'b0, store_type, load_type}, 32'h0);
    chk({tag, "_addr"},   ram_address_load | ram_address_store | data_in, 32'h0);
  endtask

  typedef struct {
    logic        port;
    logic        we;
    logic [2:0]  typ;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_data;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  // One complete transaction, entered at posedge+1 with the DUT in IDLE.
  task automatic run_txn(input int idx, input vec_t v);
    logic exp_rd, exp_wr;
    exp_rd = ~v.we & ~v.exp_err;
    exp_wr = v.we & ~v.exp_err;
    drive(v.port, 1'b1, v.we, v.typ, v.addr, v.wdata);
    #1;
    chk($sformatf("v%0d_gnt", idx), {30'b0, p1_gnt, p0_gnt}, v.port ? 32'h2 : 32'h1);
    @(posedge clk); #1;
    drive(v.port, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0);
    chk($sformatf("v%0d_issue_en", idx), {30'b0, mem_write_en, mem_read_en}, {30'b0, exp_wr, exp_rd});
    if (!v.exp_err) begin
      chk($sformatf("v%0d_addr", idx), ram_address_load, v.addr);
      chk($sformatf("v%0d_type", idx), {29'b0, store_type}, {29'b0, v.typ});
      if (v.we) chk($sformatf("v%0d_din", idx), data_in, v.wdata);
    end
    @(posedge clk); #1;
    chk($sformatf("v%0d_rvalid", idx), {30'b0, p1_rvalid, p0_rvalid}, v.port ? 32'h2 : 32'h1);
    chk($sformatf("v%0d_resp_en", idx), {30'b0, mem_write_en, mem_read_en}, 32'h0);
    chk($sformatf("v%0d_err", idx), {31'b0, rsp_err}, {31'b0, v.exp_err});
    chk($sformatf("v%0d_data", idx), rsp_data, v.exp_data);
    $display("txn %0d port=%0d we=%0d type=%03b addr=0x%08h wdata=0x%08h -> err=%0d data=0x%08h",
             idx, v.port, v.we, v.typ, v.addr, v.wdata, rsp_err, rsp_data);
    @(posedge clk); #1;
    chk($sformatf("v%0d_rvalid_off", idx), {30'b0, p1_rvalid, p0_rvalid}, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    data_out = 32'h0;

    //          port  we   type    addr          wdata         err   data
    vecs[0]  = '{1'b1, 1'b1, 3'b010, 32'h00000000, 32'h12345678, 1'b0, 32'h00000000};
    vecs[1]  = '{1'b0, 1'b1, 3'b010, 32'h00000010, 32'hDEADBEEF, 1'b0, 32'h00000000};
    vecs[2]  = '{1'b0, 1'b0, 3'b010, 32'h00000010, 32'h00000000, 1'b0, 32'hDEADBEEF};
    vecs[3]  = '{1'b0, 1'b1, 3'b000, 32'h00000013, 32'h00000080, 1'b0, 32'h00000000};
    vecs[4]  = '{1'b0, 1'b0, 3'b100, 32'h00000013, 32'h00000000, 1'b0, 32'h00000080};
    vecs[5]  = '{1'b0, 1'b0, 3'b000, 32'h00000013, 32'h00000000, 1'b0, 32'hFFFFFF80};
    vecs[6]  = '{1'b1, 1'b1, 3'b001, 32'h00000022, 32'h00008001, 1'b0, 32'h00000000};
    vecs[7]  = '{1'b1, 1'b0, 3'b101, 32'h00000022, 32'h00000000, 1'b0, 32'h00008001};
    vecs[8]  = '{1'b0, 1'b0, 3'b001, 32'h00000022, 32'h00000000, 1'b0, 32'hFFFF8001};
    vecs[9]  = '{1'b1, 1'b0, 3'b010, 32'h00000010, 32'h00000000, 1'b0, 32'h80ADBEEF};
    vecs[10] = '{1'b0, 1'b0, 3'b010, 32'h00000002, 32'h00000000, 1'b1, 32'h00000000};
    vecs[11] = '{1'b0, 1'b0, 3'b001, 32'h00000005, 32'h00000000, 1'b1, 32'h00000000};
    vecs[12] = '{1'b0, 1'b1, 3'b010, 32'h00001000, 32'hCAFEF00D, 1'b1, 32'h00000000};
    vecs[13] = '{1'b0, 1'b0, 3'b011, 32'h00000000, 32'h00000000, 1'b1, 32'h00000000};
    vecs[14] = '{1'b1, 1'b1, 3'b100, 32'h00000004, 32'h00000055, 1'b1, 32'h00000000};
    vecs[15] = '{1'b1, 1'b0, 3'b101, 32'h00000023, 32'h00000000, 1'b1, 32'h00000000};
    vecs[16] = '{1'b0, 1'b0, 3'b010, 32'h00000FFC, 32'h00000000, 1'b0, 32'h00000000};
    vecs[17] = '{1'b0, 1'b0, 3'b010, 32'h00000000, 32'h00000000, 1'b0, 32'h12345678};

    // Reset
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst_hold");
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("rst_idle");

    // Table-driven single-port transactions
    for (int i = 0; i < NV; i++) run_txn(i, vecs[i]);

    // Reset while a load sits in ISSUE: no rvalid, outputs back to reset
    drive(1'b0, 1'b1, 1'b0, 3'b010, 32'h00000010, 32'h0);
    #1;
    chk("rstiss_gnt", {31'b0, p0_gnt}, 32'h1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0);
    chk("rstiss_rd_en", {31'b0, mem_read_en}, 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_outputs("rstiss");
    @(posedge clk); #1;
    chk("rstiss_no_rvalid", {30'b0, p1_rvalid, p0_rvalid}, 32'h0);
    $display("txn reset-during-issue load 0x10 -> rvalid=%0d%0d", p1_rvalid, p0_rvalid);

    // Both ports requesting continuously: grants alternate, starting with p0
    drive(1'b0, 1'b1, 1'b0, 3'b010, 32'h00000000, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h00000010, 32'h0);
    for (int c = 0; c < 12; c++) begin
      logic [3:0] exp_v;
      int gport, rport;
      #1;
      gport = (c / 3) % 2;
      rport = ((c - 2) / 3) % 2;
      exp_v = 4'b0000;
      if (c % 3 == 0) exp_v[gport] = 1'b1;
      if (c % 3 == 2) exp_v[2 + rport] = 1'b1;
      chk($sformatf("rr_c%0d", c), {28'b0, p1_rvalid, p0_rvalid, p1_gnt, p0_gnt}, {28'b0, exp_v});
      if (c % 3 == 2) begin
        chk($sformatf("rr_data_c%0d", c), rsp_data, (rport == 1) ? 32'h80ADBEEF : 32'h12345678);
        $display("txn rr cycle %0d port=%0d data=0x%08h", c, rport, rsp_data);
      end
      @(posedge clk); #1;
    end
    idle_inputs();
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global timeout
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
